// File: rtl/dac_pkg.sv
// dac_pkg: shared mode encodings and default widths for the PWM/delta-sigma DAC array
package dac_pkg;
    localparam logic MODE_PWM = 1'b0;
    localparam logic MODE_DS  = 1'b1;
    localparam int   DEF_DW   = 32;
    localparam int   DEF_CW   = 8;
endpackage

// File: rtl/pwm_dac_lane.sv
// pwm_dac_lane: one DAC channel -- active sample/mode, PWM compare, delta-sigma accumulator, output flop
module pwm_dac_lane
    import dac_pkg::*;
#(
    parameter int DW     = DEF_DW,
    parameter int CW     = DEF_CW,
    parameter int SIGNED = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic          load,
    input  logic          mode_new,
    input  logic [DW-1:0] sample_new,
    input  logic [CW-1:0] cnt,
    output logic          dac
);
    localparam logic [DW-1:0] FLIP = (SIGNED != 0) ? {1'b1, {(DW-1){1'b0}}} : '0;
    logic [DW-1:0] sample;
    logic [DW-1:0] off;
    logic [CW-1:0] duty;
    logic [DW:0]   acc;
    logic          mode;
    assign off  = sample ^ FLIP;
    assign duty = off[DW-1 -: CW];
    // active registers swap at frame boundaries; accumulator restarts when the lane enters delta-sigma
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample <= '0;
            mode   <= MODE_PWM;
            acc    <= '0;
            dac    <= 1'b0;
        end else begin
            if (load) begin
                sample <= sample_new;
                mode   <= mode_new;
            end
            acc <= (!enable || (load && mode_new == MODE_DS && mode == MODE_PWM)) ? '0 :
                   (mode == MODE_DS) ? {1'b0, acc[DW-1:0]} + {1'b0, off} : acc;
            dac <= enable && ((mode == MODE_DS) ? acc[DW] : (cnt < duty));
        end
    end
endmodule

// File: rtl/pwm_dac_array.sv
// pwm_dac_array: frame counter, shadow sample handshake and CH PWM/delta-sigma DAC lanes
module pwm_dac_array
    import dac_pkg::*;
#(
    parameter int CH     = 2,
    parameter int DW     = DEF_DW,
    parameter int CW     = DEF_CW,
    parameter int SIGNED = 0
) (
    input  logic             clk_in,
    input  logic             RST,
    input  logic             enable,
    input  logic [CH-1:0]    mode,
    input  logic [CH*DW-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             frame_start,
    output logic             underrun,
    output logic [CH-1:0]    dac_out
);
    logic [CW-1:0]    cnt;
    logic [CH*DW-1:0] shadow_data;
    logic [CH-1:0]    shadow_mode;
    logic             shadow_full;
    logic             run;
    logic             xfer;
    logic             boundary;
    logic             load;
    logic             full_next;
    assign xfer      = data_valid && data_ready;
    assign boundary  = enable && (!run || (&cnt));
    assign load      = boundary && shadow_full;
    assign full_next = xfer || (shadow_full && !load);
    // counter restarts at every boundary (wrap or enable rise); ready mirrors the next shadow state
    always_ff @(posedge clk_in or posedge RST) begin
        if (RST) begin
            cnt         <= '0;
            run         <= 1'b0;
            shadow_data <= '0;
            shadow_mode <= '0;
            shadow_full <= 1'b0;
            data_ready  <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            run         <= enable;
            cnt         <= (enable && !boundary) ? cnt + 1'b1 : '0;
            shadow_full <= full_next;
            data_ready  <= !full_next;
            frame_start <= boundary;
            underrun    <= boundary && !shadow_full;
            if (xfer) begin
                shadow_data <= data_in;
                shadow_mode <= mode;
            end
        end
    end
    for (genvar k = 0; k < CH; k++) begin : g_lane
        pwm_dac_lane #(.DW(DW), .CW(CW), .SIGNED(SIGNED)) u_lane (
            .clk       (clk_in),
            .rst       (RST),
            .enable    (enable),
            .load      (load),
            .mode_new  (shadow_mode[k]),
            .sample_new(shadow_data[k*DW +: DW]),
            .cnt       (cnt),
            .dac       (dac_out[k])
        );
    end
endmodule

// File: doc/pwm_dac_array.md
PWM_DAC_ARRAY -- requirements
Module: pwm_dac_array

Interface
REQ-001 Parameter CH, default 2, number of DAC output channels (1..8).
REQ-002 Parameter DW, default 32, sample width per channel.
REQ-003 Parameter CW, default 8, PWM counter width; frame length is 2^CW clocks.
REQ-004 Parameter SIGNED, default 0; 1 means samples are two's complement and are converted to offset binary by inverting the MSB.
REQ-005 clk_in  input  1  single block clock; all logic is on its rising edge.
REQ-006 RST  input  1  reset, asynchronous and active-high.
REQ-007 enable  input  1  1 = run; 0 = outputs held low and counters/accumulators held cleared.
REQ-008 mode  input  CH  per-channel mode select: 0 = PWM, 1 = first-order delta-sigma.
REQ-009 data_in  input  CH*DW  packed samples; channel k occupies bits [k*DW +: DW].
REQ-010 data_valid  input  1  data_in holds a new sample set for all channels.
REQ-011 data_ready  output  1  block can accept a sample set this cycle.
REQ-012 frame_start  output  1  one-cycle pulse on the first clock of each PWM frame.
REQ-013 underrun  output  1  one-cycle pulse when a frame boundary finds no new sample set.
REQ-014 dac_out  output  CH  registered 1-bit DAC outputs, one per channel.

Function
REQ-015 A transfer occurs on any clock with data_valid=1 and data_ready=1; data_in and the mode vector are then captured into a shadow register and shadow_full is set.
REQ-016 data_ready SHALL be registered and equal ~shadow_full as of the previous clock edge; data_valid with data_ready=0 is ignored and SHALL NOT corrupt the shadow.
REQ-017 Frame counter cnt is CW bits, increments each clock while enable=1, and wraps 2^CW-1 -> 0; the wrap clock is the frame boundary.
REQ-018 At each frame boundary, if shadow_full=1, shadow samples and mode move to the active registers and shadow_full clears; otherwise the active registers keep their values and underrun pulses.
REQ-019 Simultaneous transfer and boundary: the boundary uses the pre-transfer shadow state; with the shadow empty, underrun pulses and the new set stays in the shadow for the next frame.
REQ-020 frame_start SHALL pulse on the clock following each boundary, when cnt = 0.
REQ-021 PWM lane: duty = top CW bits of the offset-binary active sample; dac_out = 1 when cnt < duty; duty 0 gives constant 0; maximum duty gives 2^CW-1 high clocks per frame.
REQ-022 Delta-sigma lane: DW+1-bit accumulator, acc <= acc[DW-1:0] + sample each clock; dac_out = carry bit acc[DW]; 1-density over 2^DW clocks = sample/2^DW.
REQ-023 Mode changes take effect only at a frame boundary; the delta-sigma accumulator clears when its lane enters delta-sigma mode.
REQ-024 dac_out has one clock of latency from the cnt/acc state to the output pin.
REQ-025 When enable falls: on the next clock, cnt, accumulators and dac_out clear, and underrun/frame_start stay 0; shadow contents and the handshake are preserved.
REQ-026 When enable rises: the first enabled clock is a frame boundary (cnt 0 -> 1 sequence starts), applying any pending shadow.

Reset
REQ-027 RST asserted asynchronously clears cnt, shadow, shadow_full, active samples (0), active mode (PWM), accumulators, dac_out=0, data_ready=0, frame_start=0 and underrun=0.
REQ-028 data_ready SHALL rise on the first clock after RST deasserts; a reset mid-frame or mid-transfer discards all data with no partial state.

Structure
REQ-029 Mode encodings (MODE_PWM=0, MODE_DS=1) and the default CW/DW values SHALL live in shared package dac_pkg.
REQ-030 Per-channel logic (offset conversion, active register, PWM compare, delta-sigma accumulator, output flop) SHALL be sub-module pwm_dac_lane, instantiated CH times by a generate loop; the counter, shadow and handshake remain in the top.

Verification
REQ-031 CW=8, DW=32, SIGNED=0, PWM: load 0x40000000 -> from the second frame, dac_out[0] is high for 64 of every 256 clocks.
REQ-032 SIGNED=1, PWM: load 0x00000000 -> 128 high clocks per frame; load 0x80000000 -> constant 0.
REQ-033 Delta-sigma, DW=32: load 0x80000000 -> after the boundary, dac_out alternates 1,0,1,0...
REQ-034 Hold data_valid=0 across two boundaries -> underrun pulses twice and the previous duty persists; a transfer on a boundary clock with the shadow empty -> underrun pulses and the data applies at the next boundary.
REQ-035 Two back-to-back valid sets within one frame -> the first is accepted, data_ready=0 until the boundary, and the second is accepted on the clock after data_ready returns to 1.
REQ-036 Assert RST at cnt=100 with the shadow full -> all outputs are 0 immediately, and data_ready=1 one clock after release.
